// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the SIPO deserializer.
// SIPO_PARITY_EN appends one even-parity bit to every frame.
package sipo_pkg;

`ifdef SIPO_PARITY_EN
  localparam int SIPO_PAR_BITS = 1;
`else
  localparam int SIPO_PAR_BITS = 0;
`endif

  function automatic int SIPO_CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int sipo_frame_len(input int width);
    return width + SIPO_PAR_BITS;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Frame bit counter: enable, synchronous clear, terminal count and wrap.
// Terminal count flags the last bit position of a frame.
module sipo_bit_counter #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial-in parallel-out deserializer with valid/ready holding register.
// Define SIPO_PARITY_EN for a trailing even-parity bit and parity_err output.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_en,
  input  logic                  align,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
`ifdef SIPO_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  overrun
);

  localparam int FRAME_LEN = sipo_frame_len(DATA_WIDTH);
  localparam int CNT_W     = SIPO_CNT_W(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] cand;
  logic                  accept;
  logic                  tc;
  logic                  word_done;

  assign accept    = din_en && !align;
  assign word_done = accept && tc;

  sipo_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (accept),
    .clr    (align),
    .tc     (tc)
  );

`ifdef SIPO_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;

  // Data bits are complete before the parity bit arrives.
  assign cand       = sr_q;
  assign parity_err = perr_q;
`else
  logic sr_unused;

  assign cand      = {din, sr_q[DATA_WIDTH-1:1]};
  assign sr_unused = sr_q[0];
`endif

  always_comb begin
    sr_d         = sr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
`ifdef SIPO_PARITY_EN
    par_d        = par_q;
    perr_d       = perr_q;
`endif
    if (align || word_done) begin
      sr_d = '0;
`ifdef SIPO_PARITY_EN
      par_d = 1'b0;
`endif
    end else if (accept) begin
      sr_d = {din, sr_q[DATA_WIDTH-1:1]};
`ifdef SIPO_PARITY_EN
      par_d = par_q ^ din;
`endif
    end
    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
    if (word_done) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = cand;
        dout_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
        perr_d = par_q ^ din;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sr_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      sr_q         <= sr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
`ifdef SIPO_PARITY_EN
      par_q        <= par_d;
      perr_q       <= perr_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (DATA_WIDTH=16).
// Inputs change and outputs are sampled on the falling edge.
module tb_sipo_deserializer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        din;
  logic        din_en;
  logic        align;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;
`ifdef SIPO_PARITY_EN
  logic        parity_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.DATA_WIDTH(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_en     (din_en),
    .align      (align),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
`ifdef SIPO_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun)
  );

  always @(posedge clk) begin
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    din    = b;
    din_en = 1'b1;
    @(negedge clk);
    din_en = 1'b0;
    din    = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int lo,
                           input int hi, input int gap);
    for (int i = lo; i <= hi; i++) send_bit(w[i], gap);
  endtask

  task automatic send_par(input logic b);
`ifdef SIPO_PARITY_EN
    send_bit(b, 0);
`else
    if (b) begin end
`endif
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_bits(w, 0, 15, gap);
    send_par(^w);
  endtask

  initial begin
    resetn     = 1'b0;
    din        = 1'b0;
    din_en     = 1'b0;
    align      = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    dout_ready = 1'b1;
    send_word(16'hA5C3, 0);
    chk("a5c3_dout", 32'(dout), 32'hA5C3);
    chk("a5c3_valid", 32'(dout_valid), 32'h1);
    chk("a5c3_ovr", 32'(overrun), 32'h0);
    @(negedge clk);
    chk("a5c3_consumed", 32'(dout_valid), 32'h0);

    send_bits(16'h1234, 0, 15, 3);
    send_par(^16'h1234);
    chk("gap_dout", 32'(dout), 32'h1234);
    chk("gap_ovr_cnt", 32'(ov_cnt), 32'h0);

    dout_ready = 1'b0;
    @(negedge clk);
    send_word(16'h00FF, 0);
    chk("bp_first_dout", 32'(dout), 32'h00FF);
    send_word(16'hFF00, 0);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_dout", 32'(dout), 32'h00FF);
    chk("ovr_valid", 32'(dout_valid), 32'h1);
    @(negedge clk);
    chk("ovr_one_cycle", 32'(overrun), 32'h0);
    chk("ovr_cnt", 32'(ov_cnt), 32'h1);
    dout_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained", 32'(dout_valid), 32'h0);

    dout_ready = 1'b0;
    send_word(16'h1111, 0);
    chk("h1111_dout", 32'(dout), 32'h1111);
`ifdef SIPO_PARITY_EN
    send_bits(16'h2222, 0, 15, 0);
    dout_ready = 1'b1;
    send_bit(^16'h2222, 0);
`else
    send_bits(16'h2222, 0, 14, 0);
    dout_ready = 1'b1;
    send_bit(1'b0, 0);
`endif
    dout_ready = 1'b0;
    chk("swap_dout", 32'(dout), 32'h2222);
    chk("swap_valid", 32'(dout_valid), 32'h1);
    @(negedge clk);
    chk("swap_no_ovr", 32'(ov_cnt), 32'h1);
    dout_ready = 1'b1;
    @(negedge clk);

    send_bits(16'h007F, 0, 6, 0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_valid", 32'(dout_valid), 32'h0);
    chk("mid_rst_ovr", 32'(overrun), 32'h0);
    dout_ready = 1'b0;
    send_word(16'hBEEF, 0);
    chk("beef_dout", 32'(dout), 32'hBEEF);
    chk("beef_valid", 32'(dout_valid), 32'h1);

    send_bits(16'hFFFF, 0, 6, 0);
    align  = 1'b1;
    din    = 1'b1;
    din_en = 1'b1;
    @(negedge clk);
    align  = 1'b0;
    din_en = 1'b0;
    din    = 1'b0;
    chk("align_hold_dout", 32'(dout), 32'hBEEF);
    chk("align_hold_valid", 32'(dout_valid), 32'h1);
    dout_ready = 1'b1;
    @(negedge clk);
    chk("align_consume", 32'(dout_valid), 32'h0);
    dout_ready = 1'b0;
    send_word(16'h4321, 0);
    chk("align_next_dout", 32'(dout), 32'h4321);
    chk("align_ovr_cnt", 32'(ov_cnt), 32'h1);

`ifdef SIPO_PARITY_EN
    dout_ready = 1'b1;
    send_bits(16'h0003, 0, 15, 0);
    send_bit(1'b0, 0);
    chk("par_ok_dout", 32'(dout), 32'h0003);
    chk("par_ok_err", 32'(parity_err), 32'h0);
    send_bits(16'h0007, 0, 15, 0);
    send_bit(1'b0, 0);
    chk("par_bad_dout", 32'(dout), 32'h0007);
    chk("par_bad_err", 32'(parity_err), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
